hazard_sequencer: RTL and testbench

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

---
 rtl/hazard_sequencer_if.sv | 40 ++++
 rtl/hazard_sequencer.sv | 137 +++++++++++++
 tb/tb_hazard_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_sequencer_if.sv
// Pipeline hazard control bundle between the pipeline and the hazard sequencer.
// The pipeline side (master) drives the hazard sources and consumes the
// control strobes; the sequencer side (slave) does the reverse.
// Control strobes are level signals valid in the same cycle as the inputs that
// produced them; there is no valid/ready handshake, the pipeline registers
// simply sample the strobes on the next rising clock edge.
interface hazard_sequencer_if;
    logic [3:0]  id_rs;
    logic [3:0]  id_rt;
    logic        id_ex_memread;
    logic [3:0]  id_ex_rd;
    logic        branch_taken;
    logic        ex_start;
    logic [3:0]  ex_latency;
    logic        mem_busy;
    logic        halt_id;
    logic        resume;
    logic        pc_write;
    logic        if_id_write;
    logic        if_flush;
    logic        id_ex_write;
    logic        id_ex_bubble;
    logic [15:0] stall_cnt;
    logic [7:0]  flush_cnt;
    logic [1:0]  dbg_state;

    modport master (
        output id_rs, id_rt, id_ex_memread, id_ex_rd, branch_taken,
               ex_start, ex_latency, mem_busy, halt_id, resume,
        input  pc_write, if_id_write, if_flush, id_ex_write, id_ex_bubble,
               stall_cnt, flush_cnt, dbg_state
    );

    modport slave (
        input  id_rs, id_rt, id_ex_memread, id_ex_rd, branch_taken,
               ex_start, ex_latency, mem_busy, halt_id, resume,
        output pc_write, if_id_write, if_flush, id_ex_write, id_ex_bubble,
               stall_cnt, flush_cnt, dbg_state
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Hazard sequencer: resolves redirects, multi-cycle EX stalls, load-use
// stalls, HALT and fetch back-pressure into pipeline register controls.
// Controls are combinational from state and inputs so the pipeline registers
// act on them at the same edge; state and event counters are registered.
module hazard_sequencer (
    input  logic               clock,
    input  logic               reset,
    hazard_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        EX_WAIT = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [15:0] r_stall_cnt;
    logic [7:0]  r_flush_cnt;

    state_t      w_next_state;
    logic [3:0]  w_next_cnt;
    logic        w_load_use;
    logic        w_redirect;
    logic        w_pc_write;
    logic        w_if_id_write;
    logic        w_if_flush;
    logic        w_id_ex_write;
    logic        w_id_ex_bubble;

    // A load in EX whose destination feeds the instruction in ID; r0 never hazards.
    assign w_load_use = bus.id_ex_memread && (bus.id_ex_rd != 4'd0) &&
                        ((bus.id_ex_rd == bus.id_rs) || (bus.id_ex_rd == bus.id_rt));

    // Next state and pipeline controls, highest-priority hazard first.
    always_comb begin
        w_next_state   = r_state;
        w_next_cnt     = r_cnt;
        w_redirect     = 1'b0;
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_if_flush     = 1'b0;
        w_id_ex_write  = 1'b1;
        w_id_ex_bubble = 1'b0;
        if (reset) begin
            // Flush IF/ID and bubble ID/EX while holding the PC; if_id_write
            // stays high so the flush actually lands in IF/ID.
            w_pc_write     = 1'b0;
            w_if_flush     = 1'b1;
            w_id_ex_bubble = 1'b1;
            w_next_state   = RUN;
            w_next_cnt     = 4'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (bus.branch_taken) begin
                        w_if_flush     = 1'b1;
                        w_id_ex_bubble = 1'b1;
                        w_redirect     = 1'b1;
                    end else if (bus.ex_start && (bus.ex_latency >= 4'd2)) begin
                        // First stall cycle; L=2 needs no more, longer ops wait out L-2 more.
                        w_pc_write    = 1'b0;
                        w_if_id_write = 1'b0;
                        w_id_ex_write = 1'b0;
                        if (bus.ex_latency >= 4'd3) begin
                            w_next_state = EX_WAIT;
                            w_next_cnt   = bus.ex_latency - 4'd2;
                        end
                    end else if (w_load_use) begin
                        w_pc_write     = 1'b0;
                        w_if_id_write  = 1'b0;
                        w_id_ex_bubble = 1'b1;
                    end else if (bus.halt_id) begin
                        w_pc_write    = 1'b0;
                        w_if_id_write = 1'b0;
                        w_next_state  = HALTED;
                    end else if (bus.mem_busy) begin
                        // Fetch not ready: hold PC and put a NOP into IF/ID.
                        w_pc_write = 1'b0;
                        w_if_flush = 1'b1;
                    end
                end
                EX_WAIT: begin
                    w_pc_write    = 1'b0;
                    w_if_id_write = 1'b0;
                    w_id_ex_write = 1'b0;
                    if (r_cnt == 4'd1) begin
                        w_next_state = RUN;
                        w_next_cnt   = 4'd0;
                    end else begin
                        w_next_cnt = r_cnt - 4'd1;
                    end
                end
                HALTED: begin
                    w_pc_write     = 1'b0;
                    w_if_id_write  = 1'b0;
                    w_id_ex_bubble = 1'b1;
                    if (bus.resume) begin
                        w_next_state = RUN;
                    end
                end
                default: begin
                    w_next_state = RUN;
                    w_next_cnt   = 4'd0;
                end
            endcase
        end
    end

    // State, EX countdown and saturating stall/flush event counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= RUN;
            r_cnt       <= 4'd0;
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if ((r_state != HALTED) && !w_pc_write && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_redirect && (r_flush_cnt != 8'hFF)) begin
                r_flush_cnt <= r_flush_cnt + 8'd1;
            end
        end
    end

    assign bus.pc_write     = w_pc_write;
    assign bus.if_id_write  = w_if_id_write;
    assign bus.if_flush     = w_if_flush;
    assign bus.id_ex_write  = w_id_ex_write;
    assign bus.id_ex_bubble = w_id_ex_bubble;
    assign bus.stall_cnt    = r_stall_cnt;
    assign bus.flush_cnt    = r_flush_cnt;
    assign bus.dbg_state    = r_state;
endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer. Inputs change on the falling edge,
// controls are checked 1ns later, counters after the following rising edge.
module tb_hazard_sequencer;
    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_EX_WAIT = 2'd1;
    localparam logic [1:0] S_HALTED  = 2'd2;

    // Control vector order: {pc_write, if_id_write, if_flush, id_ex_write, id_ex_bubble}
    localparam logic [4:0] C_RESET  = 5'b01111;
    localparam logic [4:0] C_NORMAL = 5'b11010;
    localparam logic [4:0] C_LDUSE  = 5'b00011;
    localparam logic [4:0] C_EXSTL  = 5'b00000;
    localparam logic [4:0] C_REDIR  = 5'b11111;
    localparam logic [4:0] C_MEMBSY = 5'b01110;
    localparam logic [4:0] C_HALTID = 5'b00010;
    localparam logic [4:0] C_HALTED = 5'b00011;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;
    logic [15:0] exp_q[$];

    hazard_sequencer_if bus ();

    hazard_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock and watchdog
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ctrl(input string tag, input logic [4:0] exp);
        logic [4:0] ctrl;
        #1;
        ctrl = {bus.pc_write, bus.if_id_write, bus.if_flush, bus.id_ex_write, bus.id_ex_bubble};
        exp_q.push_back({11'd0, exp});
        check(tag, {11'd0, ctrl}, exp_q.pop_front());
    endtask

    // Driver tasks
    task automatic idle();
        bus.id_rs         = 4'd0;
        bus.id_rt         = 4'd0;
        bus.id_ex_memread = 1'b0;
        bus.id_ex_rd      = 4'd0;
        bus.branch_taken  = 1'b0;
        bus.ex_start      = 1'b0;
        bus.ex_latency    = 4'd0;
        bus.mem_busy      = 1'b0;
        bus.halt_id       = 1'b0;
        bus.resume        = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic start_ex(input logic [3:0] lat);
        idle();
        bus.ex_start   = 1'b1;
        bus.ex_latency = lat;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        idle();
        @(negedge clock);

        // Reset behaviour
        check_ctrl("reset_ctrl", C_RESET);
        cycle();
        check_ctrl("reset_ctrl_hold", C_RESET);
        check("reset_stall_cnt", bus.stall_cnt, 16'd0);
        check("reset_flush_cnt", {8'd0, bus.flush_cnt}, 16'd0);
        check("reset_state", {14'd0, bus.dbg_state}, {14'd0, S_RUN});
        reset = 1'b0;
        check_ctrl("normal_after_reset", C_NORMAL);
        cycle();

        // Load-use on rs, then rd=0 (no hazard), then on rt
        bus.id_ex_memread = 1'b1;
        bus.id_ex_rd = 4'd5;
        bus.id_rs = 4'd5;
        check_ctrl("lduse_rs_ctrl", C_LDUSE);
        cycle();
        check("lduse_rs_stall", bus.stall_cnt, 16'd1);
        bus.id_ex_rd = 4'd0;
        bus.id_rs = 4'd0;
        check_ctrl("lduse_rd0_ctrl", C_NORMAL);
        cycle();
        check("lduse_rd0_stall", bus.stall_cnt, 16'd1);
        bus.id_ex_rd = 4'd7;
        bus.id_rs = 4'd3;
        bus.id_rt = 4'd7;
        check_ctrl("lduse_rt_ctrl", C_LDUSE);
        cycle();
        bus.id_rt = 4'd9;
        check_ctrl("lduse_nomatch_ctrl", C_NORMAL);
        cycle();
        check("lduse_rt_stall", bus.stall_cnt, 16'd2);

        // L=4 multi-cycle op: stalls at N..N+2, inputs ignored in EX_WAIT
        start_ex(4'd4);
        check_ctrl("ex4_n0", C_EXSTL);
        cycle();
        check("ex4_state", {14'd0, bus.dbg_state}, {14'd0, S_EX_WAIT});
        idle();
        bus.branch_taken = 1'b1;
        bus.halt_id = 1'b1;
        check_ctrl("ex4_n1_ignore", C_EXSTL);
        cycle();
        idle();
        bus.mem_busy = 1'b1;
        check_ctrl("ex4_n2", C_EXSTL);
        cycle();
        idle();
        check_ctrl("ex4_n3_resume", C_NORMAL);
        check("ex4_stall", bus.stall_cnt, 16'd5);
        check("ex4_no_flush", {8'd0, bus.flush_cnt}, 16'd0);
        cycle();

        // L=2 stalls once and stays in RUN; L=1 is ignored
        start_ex(4'd2);
        check_ctrl("ex2_ctrl", C_EXSTL);
        cycle();
        check("ex2_state", {14'd0, bus.dbg_state}, {14'd0, S_RUN});
        start_ex(4'd1);
        check_ctrl("ex1_ignored", C_NORMAL);
        cycle();
        check("ex2_stall", bus.stall_cnt, 16'd6);

        // Redirect beats ex_start and load-use in the same cycle
        start_ex(4'd4);
        bus.branch_taken = 1'b1;
        bus.id_ex_memread = 1'b1;
        bus.id_ex_rd = 4'd5;
        bus.id_rs = 4'd5;
        check_ctrl("combo_redirect", C_REDIR);
        cycle();
        check("combo_state", {14'd0, bus.dbg_state}, {14'd0, S_RUN});
        check("combo_flush", {8'd0, bus.flush_cnt}, 16'd1);
        check("combo_stall", bus.stall_cnt, 16'd6);
        idle();
        check_ctrl("combo_after", C_NORMAL);
        cycle();

        // Fetch back-pressure for 3 cycles
        for (int i = 0; i < 3; i++) begin
            bus.mem_busy = 1'b1;
            check_ctrl($sformatf("membusy_%0d", i), C_MEMBSY);
            cycle();
        end
        idle();
        check("membusy_stall", bus.stall_cnt, 16'd9);

        // HALT, 10 idle cycles with distractions, then resume
        bus.halt_id = 1'b1;
        check_ctrl("halt_id_ctrl", C_HALTID);
        cycle();
        check("halt_state", {14'd0, bus.dbg_state}, {14'd0, S_HALTED});
        check("halt_id_stall", bus.stall_cnt, 16'd10);
        for (int i = 0; i < 10; i++) begin
            idle();
            bus.branch_taken = (i % 2 == 0);
            bus.ex_start = 1'b1;
            bus.ex_latency = 4'd5;
            check_ctrl($sformatf("halted_%0d", i), C_HALTED);
            cycle();
        end
        idle();
        check("halted_stall", bus.stall_cnt, 16'd10);
        check("halted_flush", {8'd0, bus.flush_cnt}, 16'd1);
        bus.resume = 1'b1;
        check_ctrl("resume_cycle", C_HALTED);
        cycle();
        idle();
        check_ctrl("after_resume", C_NORMAL);
        check("resume_stall", bus.stall_cnt, 16'd10);
        cycle();

        // Reset in the second EX_WAIT cycle of an L=6 op
        start_ex(4'd6);
        check_ctrl("ex6_n0", C_EXSTL);
        cycle();
        idle();
        cycle();
        check("ex6_state_wait", {14'd0, bus.dbg_state}, {14'd0, S_EX_WAIT});
        reset = 1'b1;
        check_ctrl("ex6_reset_ctrl", C_RESET);
        cycle();
        reset = 1'b0;
        check("ex6_reset_stall", bus.stall_cnt, 16'd0);
        check("ex6_reset_flush", {8'd0, bus.flush_cnt}, 16'd0);
        check("ex6_reset_state", {14'd0, bus.dbg_state}, {14'd0, S_RUN});
        check_ctrl("ex6_post_reset", C_NORMAL);
        cycle();

        // 300 redirects saturate flush_cnt
        for (int i = 0; i < 300; i++) begin
            bus.branch_taken = 1'b1;
            cycle();
            if (i == 254) begin
                check("flush_at_255", {8'd0, bus.flush_cnt}, 16'd255);
            end
        end
        idle();
        check("flush_sat", {8'd0, bus.flush_cnt}, 16'h00FF);
        check("flush_sat_stall", bus.stall_cnt, 16'd0);
        check_ctrl("final_normal", C_NORMAL);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
